// File: rtl/alu_if.sv
// alu_if -- operand/result bundle for the two-stage ALU.
//   op       : 0 = float32 add, 1 = signed 32x32 multiply
//   x, y     : operands (float bit patterns or two's-complement integers)
//   result   : registered result, two edges after the operands are captured
//   overflow : registered overflow flag, aligned with result
// master drives operands and observes results; slave is the ALU side.
interface alu_if;
  logic        op;
  logic [31:0] x;
  logic [31:0] y;
  logic [31:0] result;
  logic        overflow;

  modport master (output op, x, y, input result, overflow);
  modport slave  (input op, x, y, output result, overflow);
endinterface

// File: rtl/alu.sv
// alu -- two-stage pipelined ALU: IEEE-754 single-precision add (op=0) or
// signed 32-bit multiply with overflow detection (op=1).
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset, clears every pipeline register
//   bus : alu_if.slave (op, x, y in; result, overflow out)
// Stage 1 registers op/x/y; stage 2 registers the computed result, so a
// result appears after the second edge following operand capture.
// Configuration macro: ALU_ROUND_NEAREST_EN selects round-to-nearest-even
// for the float add; without it the float add truncates toward zero.
// Float simplifications: subnormal inputs act as signed zero, subnormal
// results flush to +0, every NaN produces the quiet NaN 0x7FC00000.
module alu (
  input  logic clk,
  input  logic rst,
  alu_if.slave bus
);

  logic        op_q;
  logic [31:0] x_q;
  logic [31:0] y_q;
  logic [31:0] result_q;
  logic        overflow_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
    end else begin
      op_q <= bus.op;
      x_q  <= bus.x;
      y_q  <= bus.y;
    end
  end

  // Integer multiply: the low 64 bits of the product of sign-extended
  // operands equal the exact signed product.
  logic [63:0] x_ext;
  logic [63:0] y_ext;
  logic [63:0] prod;
  logic [32:0] prod_hi;
  logic        mul_ovf;

  assign x_ext   = {{32{x_q[31]}}, x_q};
  assign y_ext   = {{32{y_q[31]}}, y_q};
  assign prod    = x_ext * y_ext;
  assign prod_hi = prod[63:31];
  // Fits in 32 bits only when bits 63..31 are a pure sign extension.
  assign mul_ovf = !((prod_hi == '0) || (prod_hi == '1));

  // Float add
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic              a_big;
  logic              s_big;
  logic [7:0]        e_big, e_small, e_diff;
  logic [4:0]        sh_amt;
  logic [26:0]       m_big, m_small;
  logic [53:0]       sh_wide;
  logic [26:0]       m_aligned;
  logic [27:0]       m_sum;
  logic [4:0]        lz;
  logic [26:0]       m_norm;
  logic              round_up;
  logic [24:0]       m_round;
  logic signed [9:0] e_norm;
  logic signed [9:0] e_final;
  logic [31:0]       fadd_res;
  logic              fadd_ovf;

  always_comb begin
    a_zero = (x_q[30:23] == 8'd0);
    b_zero = (y_q[30:23] == 8'd0);
    a_inf  = (x_q[30:23] == 8'hFF) && (x_q[22:0] == 23'd0);
    b_inf  = (y_q[30:23] == 8'hFF) && (y_q[22:0] == 23'd0);
    a_nan  = (x_q[30:23] == 8'hFF) && (x_q[22:0] != 23'd0);
    b_nan  = (y_q[30:23] == 8'hFF) && (y_q[22:0] != 23'd0);

    // Exponent sits above mantissa, so the raw magnitude bits compare
    // as the magnitudes themselves.
    a_big = (x_q[30:0] >= y_q[30:0]);
    if (a_big) begin
      s_big   = x_q[31];
      e_big   = x_q[30:23];
      e_small = y_q[30:23];
      m_big   = {1'b1, x_q[22:0], 3'b000};
      m_small = {1'b1, y_q[22:0], 3'b000};
    end else begin
      s_big   = y_q[31];
      e_big   = y_q[30:23];
      e_small = x_q[30:23];
      m_big   = {1'b1, y_q[22:0], 3'b000};
      m_small = {1'b1, x_q[22:0], 3'b000};
    end

    // Align: the three low bits are guard/round/sticky; everything shifted
    // past them collapses into the sticky bit. Beyond 27 the small operand
    // is entirely sticky.
    e_diff    = e_big - e_small;
    sh_amt    = (e_diff > 8'd27) ? 5'd27 : e_diff[4:0];
    sh_wide   = {m_small, 27'd0} >> sh_amt;
    m_aligned = {sh_wide[53:28], sh_wide[27] | (|sh_wide[26:0])};

    if (x_q[31] == y_q[31]) m_sum = {1'b0, m_big} + {1'b0, m_aligned};
    else                    m_sum = {1'b0, m_big} - {1'b0, m_aligned};

    lz = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (m_sum[i]) lz = 5'(27 - i);
    end

    // lz==0 means a carry-out: shift right one, keeping the sticky bit.
    if (lz == 5'd0) m_norm = {m_sum[27:2], m_sum[1] | m_sum[0]};
    else            m_norm = m_sum[26:0] << (lz - 5'd1);
    e_norm = $signed({2'b00, e_big}) + 10'sd1 - $signed({5'b00000, lz});

`ifdef ALU_ROUND_NEAREST_EN
    round_up = m_norm[2] & (m_norm[1] | m_norm[0] | m_norm[3]);
`else
    round_up = 1'b0;
`endif
    m_round = {1'b0, m_norm[26:3]} + {24'd0, round_up};
    e_final = e_norm + (m_round[24] ? 10'sd1 : 10'sd0);

    fadd_res = '0;
    fadd_ovf = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && (x_q[31] != y_q[31]))) begin
      fadd_res = 32'h7FC0_0000;
    end else if (a_inf) begin
      fadd_res = x_q;
    end else if (b_inf) begin
      fadd_res = y_q;
    end else if (a_zero && b_zero) begin
      fadd_res = '0;
    end else if (a_zero) begin
      fadd_res = y_q;
    end else if (b_zero) begin
      fadd_res = x_q;
    end else if (m_sum == '0) begin
      fadd_res = '0;
    end else if (e_final >= 10'sd255) begin
      fadd_res = {s_big, 8'hFF, 23'd0};
      fadd_ovf = 1'b1;
    end else if (e_final <= 10'sd0) begin
      fadd_res = '0;
    end else begin
      // A rounding carry leaves mantissa 1.000..., whose stored field is 0.
      fadd_res = {s_big, e_final[7:0], m_round[24] ? 23'd0 : m_round[22:0]};
    end
  end

`ifndef ALU_ROUND_NEAREST_EN
  // Guard/round/sticky only feed rounding in the nearest-even build.
  logic unused_grs;
  assign unused_grs = |m_norm[2:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else if (op_q) begin
      result_q   <= prod[31:0];
      overflow_q <= mul_ovf;
    end else begin
      result_q   <= fadd_res;
      overflow_q <= fadd_ovf;
    end
  end

  assign bus.result   = result_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu -- directed table, reset/stability sequences and a randomized
// pipelined stream checked against an exact-arithmetic reference model.
module tb_alu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_if bus();

  alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] res;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        ov;
    logic [31:0] x;
    logic [31:0] y;
    logic        op;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] got_r,
                     input logic [31:0] exp_r, input logic got_o,
                     input logic exp_o);
    checks++;
    if (got_r !== exp_r || got_o !== exp_o) begin
      errors++;
      $display("FAIL %s: result=%08h overflow=%b, expected result=%08h overflow=%b",
               name, got_r, got_o, exp_r, exp_o);
    end
  endtask

  // Float add computed exactly on a wide integer grid, then rounded once.
  function automatic void fadd_model(input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic ov);
    int ea, eb, emin, p, er;
    logic [319:0] ma, mb, s, mant, rem;
    logic sa, sb, sr, up;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    ov = 1'b0;
    r  = '0;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    sa = a[31];
    sb = b[31];
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan || (a_inf && b_inf && sa != sb)) r = 32'h7FC00000;
    else if (a_inf) r = a;
    else if (b_inf) r = b;
    else if (a_zero && b_zero) r = '0;
    else if (a_zero) r = b;
    else if (b_zero) r = a;
    else begin
      emin = (ea < eb) ? ea : eb;
      ma = {296'd0, 1'b1, a[22:0]};
      mb = {296'd0, 1'b1, b[22:0]};
      ma = ma << (ea - emin);
      mb = mb << (eb - emin);
      if (sa == sb)      begin s = ma + mb; sr = sa; end
      else if (ma >= mb) begin s = ma - mb; sr = sa; end
      else               begin s = mb - ma; sr = sb; end
      if (s == 0) r = '0;
      else begin
        p = 0;
        for (int i = 0; i < 320; i++) if (s[i]) p = i;
        er = emin + p - 23;
        if (p >= 23) begin
          mant = s >> (p - 23);
          rem  = s - (mant << (p - 23));
          up   = 1'b0;
`ifdef ALU_ROUND_NEAREST_EN
          if (p >= 24) begin
            logic [319:0] half;
            half = 320'd1 << (p - 24);
            up = (rem > half) || (rem == half && mant[0]);
          end
`endif
          if (rem == 0) up = 1'b0;
          mant = mant + {319'd0, up};
          if (mant[24]) begin
            mant = mant >> 1;
            er++;
          end
        end else begin
          mant = s << (23 - p);
        end
        if (er >= 255) begin
          r  = {sr, 8'hFF, 23'd0};
          ov = 1'b1;
        end else if (er <= 0) r = '0;
        else r = {sr, er[7:0], mant[22:0]};
      end
    end
  endfunction

  function automatic void ref_model(input logic op, input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] r, output logic ov);
    longint p;
    if (op) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      r  = p[31:0];
      ov = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else begin
      fadd_model(a, b, r, ov);
    end
  endfunction

  function automatic logic [31:0] rand_float(input logic [31:0] other);
    logic [31:0] v;
    int e;
    int k;
    k = int'($urandom_range(0, 19));
    v = $urandom;
    case (k)
      0: v = {v[31], 31'd0};
      1: v = {v[31], 8'd0, v[22:0]};
      2: v = {v[31], 8'hFF, 23'd0};
      3: v = {v[31], 8'hFF, v[22:0] | 23'd1};
      4: v = {~other[31], other[30:0]};
      5, 6, 7, 8, 9, 10, 11, 12: begin
        e = int'(other[30:23]) + int'($urandom_range(0, 8)) - 4;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        v[30:23] = 8'(e);
      end
      13: v[30:23] = 8'hFE;
      14: v[30:23] = 8'd1;
      default: ;
    endcase
    return v;
  endfunction

  vec_t tbl[$];
  exp_t q[$];

  initial begin
    logic [31:0] rx, ry, er;
    logic        rop, eo;
    exp_t        e;
    string       nm;

    tbl.push_back('{1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0});
    tbl.push_back('{1'b0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1});
    tbl.push_back('{1'b0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0});
    tbl.push_back('{1'b0, 32'hC1700000, 32'hC0A00000, 32'hC1A00000, 1'b0});
    tbl.push_back('{1'b0, 32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0});
    tbl.push_back('{1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b0});
    tbl.push_back('{1'b0, 32'h80000000, 32'h3F800000, 32'h3F800000, 1'b0});
    tbl.push_back('{1'b0, 32'hC0400000, 32'h00000000, 32'hC0400000, 1'b0});
    tbl.push_back('{1'b0, 32'h00000001, 32'h40400000, 32'h40400000, 1'b0});
    tbl.push_back('{1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0});
    tbl.push_back('{1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0});
    tbl.push_back('{1'b0, 32'hFF800000, 32'hFF800000, 32'hFF800000, 1'b0});
    tbl.push_back('{1'b0, 32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000, 1'b1});
    tbl.push_back('{1'b0, 32'h00800000, 32'h80C00000, 32'h00000000, 1'b0});
    tbl.push_back('{1'b0, 32'h40000000, 32'hBF800000, 32'h3F800000, 1'b0});
    tbl.push_back('{1'b1, 32'd3, 32'd5, 32'd15, 1'b0});
    tbl.push_back('{1'b1, 32'd8, 32'hFFFFFFFD, 32'hFFFFFFE8, 1'b0});
    tbl.push_back('{1'b1, 32'hFFFFFFF6, 32'hFFFFFFEC, 32'd200, 1'b0});
    tbl.push_back('{1'b1, 32'd123, 32'd0, 32'd0, 1'b0});
    tbl.push_back('{1'b1, 32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b1});
    tbl.push_back('{1'b1, 32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 1'b0});
    tbl.push_back('{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1});
    tbl.push_back('{1'b1, 32'h80000000, 32'd1, 32'h80000000, 1'b0});
    tbl.push_back('{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0});

    rst    = 1'b0;
    bus.op = 1'b0;
    bus.x  = '0;
    bus.y  = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", bus.result, 32'h0, bus.overflow, 1'b0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      bus.op = tbl[i].op;
      bus.x  = tbl[i].x;
      bus.y  = tbl[i].y;
      repeat (2) @(negedge clk);
      nm = $sformatf("vec%0d", i);
      chk(nm, bus.result, tbl[i].res, bus.overflow, tbl[i].ov);
    end

    // Held inputs keep the outputs stable.
    @(negedge clk);
    bus.op = 1'b1;
    bus.x  = 32'h7FFFFFFF;
    bus.y  = 32'd2;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("stable", bus.result, 32'hFFFFFFFE, bus.overflow, 1'b1);
      @(negedge clk);
    end

    // Asynchronous reset mid-stream, then exact 2-edge recovery.
    bus.op = 1'b1;
    bus.x  = 32'd3;
    bus.y  = 32'd5;
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("rst_async", bus.result, 32'h0, bus.overflow, 1'b0);
    repeat (3) @(posedge clk);
    #1 chk("rst_held", bus.result, 32'h0, bus.overflow, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("rst_edge1", bus.result, 32'h0, bus.overflow, 1'b0);
    @(posedge clk);
    #1 chk("rst_edge2", bus.result, 32'd15, bus.overflow, 1'b0);

    // Randomized back-to-back stream with random op per cycle.
    for (int c = 0; c < 1502; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        e  = q.pop_front();
        nm = $sformatf("rand op=%0b x=%08h y=%08h", e.op, e.x, e.y);
        chk(nm, bus.result, e.res, bus.overflow, e.ov);
      end
      if (c < 1500) begin
        rop = ($urandom_range(0, 2) == 0);
        if (rop) begin
          rx = $urandom;
          ry = ($urandom_range(0, 1) == 0) ? 32'($signed(16'($urandom))) : $urandom;
        end else begin
          rx = rand_float($urandom);
          ry = rand_float(rx);
        end
        bus.op = rop;
        bus.x  = rx;
        bus.y  = ry;
        ref_model(rop, rx, ry, er, eo);
        q.push_back('{er, eo, rx, ry, rop});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
